// File: rtl/ship_box_painter_pkg.sv
// Shared types and constants for the ship box painter.
package painter_pkg;

    localparam int unsigned X_W   = 8;
    localparam int unsigned Y_W   = 7;
    localparam int unsigned C_W   = 3;
    localparam int unsigned OFF_W = 4;

    localparam int unsigned DEF_SCREEN_W = 160;
    localparam int unsigned DEF_SCREEN_H = 120;

    localparam logic [C_W-1:0] BLACK = 3'b000;
    localparam logic [C_W-1:0] GREEN = 3'b010;

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        DONE
    } state_e;

    // One position/colour update for the box.
    typedef struct packed {
        logic [X_W-1:0] x;
        logic [Y_W-1:0] y;
        logic [C_W-1:0] c;
    } box_req_t;

endpackage

// File: rtl/ship_box_painter_if.sv
// Request and pixel-stream signals between the spaceship datapath, the painter and the VGA adapter.
interface ship_box_painter_if;
    import painter_pkg::*;

    logic           go;
    logic [X_W-1:0] x_in;
    logic [Y_W-1:0] y_in;
    logic [C_W-1:0] c_in;
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [C_W-1:0] c;
    logic           plot;
    logic           busy;
    logic           done;

    modport master (
        output go, x_in, y_in, c_in,
        input  x, y, c, plot, busy, done
    );

    modport slave (
        input  go, x_in, y_in, c_in,
        output x, y, c, plot, busy, done
    );

endinterface

// File: rtl/ship_box_painter_box_scanner.sv
// Row-major dx/dy offset counter shared by the erase and draw passes.
// dx_c/dy_c give the offset of the pixel that follows the current one;
// last_c flags that the current pixel is the bottom-right corner.
module box_scanner
    import painter_pkg::*;
#(
    parameter int unsigned BOX_W = 8,
    parameter int unsigned BOX_H = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_i,
    input  logic             advance_i,
    output logic [OFF_W-1:0] dx_c,
    output logic [OFF_W-1:0] dy_c,
    output logic             last_c
);

    logic [OFF_W-1:0] dx_q, dx_d;
    logic [OFF_W-1:0] dy_q, dy_d;
    logic             last_col;
    logic             last_row;

    // Next offsets in scan order and counter update.
    always_comb begin
        last_col = (dx_q == OFF_W'(BOX_W - 1));
        last_row = (dy_q == OFF_W'(BOX_H - 1));
        last_c   = last_col && last_row;
        dx_c     = last_col ? '0 : dx_q + OFF_W'(1);
        dy_c     = last_col ? dy_q + OFF_W'(1) : dy_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        if (start_i) begin
            dx_d = '0;
            dy_d = '0;
        end else if (advance_i) begin
            dx_d = dx_c;
            dy_d = dy_c;
        end
    end

    // Offset registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/ship_box_painter.sv
// Streams one pixel per clock to the VGA adapter: erases the previous box in
// BG_COLOUR, then draws the new box. Requests arriving while busy are held in
// a one-deep pending slot (last writer wins).
// Optional feature macro: SHIP_BOX_PAINTER_ERASE_EN builds the erase pass and old_* registers.
module ship_box_painter
    import painter_pkg::*;
#(
    parameter int unsigned    BOX_W     = 8,
    parameter int unsigned    BOX_H     = 4,
    parameter int unsigned    SCREEN_W  = DEF_SCREEN_W,
    parameter int unsigned    SCREEN_H  = DEF_SCREEN_H,
    parameter logic [C_W-1:0] BG_COLOUR = BLACK
) (
    input logic               clk,
    input logic               reset,
    ship_box_painter_if.slave bus
);

    localparam int unsigned SUM_X_W = X_W + 1;
    localparam int unsigned SUM_Y_W = Y_W + 1;

    state_e         state_q, state_d;
    box_req_t       new_q, new_d;
    logic           pend_q, pend_d;
    box_req_t       pend_req_q, pend_req_d;
`ifdef SHIP_BOX_PAINTER_ERASE_EN
    box_req_t       old_q, old_d;
    logic           old_valid_q, old_valid_d;
`endif

    logic [X_W-1:0] x_q, x_d;
    logic [Y_W-1:0] y_q, y_d;
    logic [C_W-1:0] c_q, c_d;
    logic           plot_q, plot_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    box_req_t         in_req;
    box_req_t         take_req;
    logic             take;
    logic             emit;
    logic             scan_start;
    logic             scan_adv;
    logic [OFF_W-1:0] dx_c, dy_c;
    logic             last_c;
    logic [X_W-1:0]   base_x;
    logic [Y_W-1:0]   base_y;
    logic [C_W-1:0]   pix_c;
    logic [OFF_W-1:0] off_x, off_y;
    logic [SUM_X_W-1:0] sum_x;
    logic [SUM_Y_W-1:0] sum_y;

    assign in_req = {bus.x_in, bus.y_in, bus.c_in};

    box_scanner #(
        .BOX_W (BOX_W),
        .BOX_H (BOX_H)
    ) u_scanner (
        .clk       (clk),
        .reset     (reset),
        .start_i   (scan_start),
        .advance_i (scan_adv),
        .dx_c      (dx_c),
        .dy_c      (dy_c),
        .last_c    (last_c)
    );

    // Next state, request capture and the next pixel to present.
    always_comb begin
        state_d     = state_q;
        new_d       = new_q;
        pend_d      = pend_q;
        pend_req_d  = pend_req_q;
`ifdef SHIP_BOX_PAINTER_ERASE_EN
        old_d       = old_q;
        old_valid_d = old_valid_q;
`endif
        x_d         = x_q;
        y_d         = y_q;
        c_d         = c_q;
        plot_d      = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b0;
        scan_start  = 1'b0;
        scan_adv    = 1'b0;
        take        = 1'b0;
        take_req    = in_req;
        emit        = 1'b0;
        base_x      = new_q.x;
        base_y      = new_q.y;
        pix_c       = new_q.c;
        off_x       = dx_c;
        off_y       = dy_c;

        case (state_q)
            IDLE: begin
                take = bus.go;
            end
`ifdef SHIP_BOX_PAINTER_ERASE_EN
            ERASE: begin
                emit = 1'b1;
                if (last_c) begin
                    state_d    = DRAW;
                    scan_start = 1'b1;
                    off_x      = '0;
                    off_y      = '0;
                end else begin
                    scan_adv = 1'b1;
                    base_x   = old_q.x;
                    base_y   = old_q.y;
                    pix_c    = BG_COLOUR;
                end
            end
`endif
            DRAW: begin
                if (last_c) begin
                    state_d     = DONE;
                    done_d      = 1'b1;
                    c_d         = BG_COLOUR;
`ifdef SHIP_BOX_PAINTER_ERASE_EN
                    old_d       = new_q;
                    old_valid_d = 1'b1;
`endif
                end else begin
                    scan_adv = 1'b1;
                    emit     = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.go) begin
                    take = 1'b1;
                end else if (pend_q) begin
                    take     = 1'b1;
                    take_req = pend_req_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // A request seen mid-operation waits in the pending slot.
        if (bus.go && (state_q == ERASE || state_q == DRAW)) begin
            pend_d     = 1'b1;
            pend_req_d = in_req;
        end

        // Starting a request presents its first pixel on the next cycle.
        if (take) begin
            new_d      = take_req;
            pend_d     = 1'b0;
            scan_start = 1'b1;
            emit       = 1'b1;
            off_x      = '0;
            off_y      = '0;
            state_d    = DRAW;
            base_x     = take_req.x;
            base_y     = take_req.y;
            pix_c      = take_req.c;
`ifdef SHIP_BOX_PAINTER_ERASE_EN
            if (old_valid_q) begin
                state_d = ERASE;
                base_x  = old_q.x;
                base_y  = old_q.y;
                pix_c   = BG_COLOUR;
            end
`endif
        end

        // Widened address so base+offset never wraps before the screen test.
        sum_x = {1'b0, base_x} + SUM_X_W'(off_x);
        sum_y = {1'b0, base_y} + SUM_Y_W'(off_y);
        if (emit) begin
            x_d    = sum_x[X_W-1:0];
            y_d    = sum_y[Y_W-1:0];
            c_d    = pix_c;
            plot_d = (sum_x < SUM_X_W'(SCREEN_W)) && (sum_y < SUM_Y_W'(SCREEN_H));
            busy_d = 1'b1;
        end
    end

    // State, request and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            new_q       <= '0;
            pend_q      <= 1'b0;
            pend_req_q  <= '0;
`ifdef SHIP_BOX_PAINTER_ERASE_EN
            old_q       <= '0;
            old_valid_q <= 1'b0;
`endif
            x_q         <= '0;
            y_q         <= '0;
            c_q         <= '0;
            plot_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            new_q       <= new_d;
            pend_q      <= pend_d;
            pend_req_q  <= pend_req_d;
`ifdef SHIP_BOX_PAINTER_ERASE_EN
            old_q       <= old_d;
            old_valid_q <= old_valid_d;
`endif
            x_q         <= x_d;
            y_q         <= y_d;
            c_q         <= c_d;
            plot_q      <= plot_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.x    = x_q;
    assign bus.y    = y_q;
    assign bus.c    = c_q;
    assign bus.plot = plot_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

// File: tb/tb_ship_box_painter.sv
// Self-checking bench for ship_box_painter: a pixel-list reference model
// predicts every cycle of each erase/draw stream, including screen clipping,
// pending requests and mid-operation reset.
module tb_ship_box_painter;

`ifdef SHIP_BOX_PAINTER_ERASE_EN
    localparam bit ERASE_ON = 1'b1;
`else
    localparam bit ERASE_ON = 1'b0;
`endif
    localparam int BW = 8;
    localparam int BH = 4;
    localparam int NPIX = BW * BH;

    logic clk;
    logic reset;

    ship_box_painter_if ifc ();

    ship_box_painter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } inj_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          lat;
    logic [20:0] obs_q[$];
    logic [18:0] exp_q[$];
    inj_t        inj_q[$];

    bit m_old_valid = 1'b0;
    int m_old_x     = 0;
    int m_old_y     = 0;

    // One expected pixel: {plot, x, y, c}.
    function automatic logic [18:0] pix(input int px, input int py, input logic [2:0] pc);
        logic on;
        on = (px < 160) && (py < 120);
        return {on, 8'(px), 7'(py), pc};
    endfunction

    // Whole expected stream of one request, then the box it leaves on screen.
    task automatic model_req(input int nx, input int ny, input logic [2:0] nc);
        exp_q = {};
        if (ERASE_ON && m_old_valid)
            for (int r = 0; r < BH; r++)
                for (int col = 0; col < BW; col++)
                    exp_q.push_back(pix(m_old_x + col, m_old_y + r, 3'b000));
        for (int r = 0; r < BH; r++)
            for (int col = 0; col < BW; col++)
                exp_q.push_back(pix(nx + col, ny + r, nc));
        m_old_valid = 1'b1;
        m_old_x     = nx;
        m_old_y     = ny;
    endtask

    task automatic start_req(input logic [7:0] rx, input logic [6:0] ry, input logic [2:0] rc);
        @(negedge clk);
        ifc.go   = 1'b1;
        ifc.x_in = rx;
        ifc.y_in = ry;
        ifc.c_in = rc;
        @(negedge clk);
        ifc.go = 1'b0;
    endtask

    task automatic step();
        @(negedge clk);
        ifc.go = 1'b0;
    endtask

    // Records outputs of cycles 1.. after go until done, applying injected go pulses.
    task automatic capture();
        obs_q = {};
        lat   = 0;
        for (int k = 1; k <= 300; k++) begin
            if (inj_q.size() > 0 && inj_q[0].k == k) begin
                ifc.go   = 1'b1;
                ifc.x_in = inj_q[0].x;
                ifc.y_in = inj_q[0].y;
                ifc.c_in = inj_q[0].c;
                inj_q.delete(0);
            end else begin
                ifc.go = 1'b0;
            end
            if (ifc.done === 1'b1) begin
                lat = k;
                break;
            end
            obs_q.push_back({ifc.busy, ifc.done, ifc.plot, ifc.x, ifc.y, ifc.c});
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        ifc.go   = 1'b0;
        ifc.x_in = '0;
        ifc.y_in = '0;
        ifc.c_in = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({ifc.x, ifc.y, ifc.c} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_xyc: got %h expected 0", {ifc.x, ifc.y, ifc.c});
        end
        n_checks++;
        if ({ifc.plot, ifc.busy, ifc.done} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_flags: got plot/busy/done=%b expected 000", {ifc.plot, ifc.busy, ifc.done});
        end
    endtask

    task automatic test_first_draw();
        int plots;
        model_req(10, 116, 3'b010);
        start_req(8'd10, 7'd116, 3'b010);
        capture();
        n_checks++;
        if (lat !== NPIX + 1) begin
            n_fail++;
            $display("FAIL first_latency: got %0d expected %0d", lat, NPIX + 1);
        end
        plots = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL first_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
        foreach (obs_q[i]) if (obs_q[i][18]) plots++;
        n_checks++;
        if (plots !== NPIX) begin
            n_fail++;
            $display("FAIL first_plot_count: got %0d expected %0d", plots, NPIX);
        end
        step();
        n_checks++;
        if ({ifc.busy, ifc.done, ifc.plot} !== 3'b000) begin
            n_fail++;
            $display("FAIL first_idle_after_done: got busy/done/plot=%b expected 000",
                     {ifc.busy, ifc.done, ifc.plot});
        end
    endtask

    task automatic test_second_draw();
        int bg;
        model_req(12, 116, 3'b010);
        start_req(8'd12, 7'd116, 3'b010);
        capture();
        n_checks++;
        if (lat !== (ERASE_ON ? 2 * NPIX + 1 : NPIX + 1)) begin
            n_fail++;
            $display("FAIL second_latency: got %0d expected %0d", lat, ERASE_ON ? 2 * NPIX + 1 : NPIX + 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL second_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
        bg = 0;
        foreach (obs_q[i]) if (obs_q[i][18] && obs_q[i][2:0] == 3'b000) bg++;
        n_checks++;
        if (bg !== (ERASE_ON ? NPIX : 0)) begin
            n_fail++;
            $display("FAIL second_bg_writes: got %0d expected %0d", bg, ERASE_ON ? NPIX : 0);
        end
    endtask

    task automatic test_offscreen();
        int plots;
        model_req(156, 10, 3'b101);
        start_req(8'd156, 7'd10, 3'b101);
        capture();
        n_checks++;
        if (lat !== exp_q.size() + 1) begin
            n_fail++;
            $display("FAIL offscreen_latency: got %0d expected %0d", lat, exp_q.size() + 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL offscreen_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
        plots = 0;
        foreach (obs_q[i]) if (obs_q[i][18]) plots++;
        n_checks++;
        if (plots !== (ERASE_ON ? NPIX + 16 : 16)) begin
            n_fail++;
            $display("FAIL offscreen_plot_count: got %0d expected %0d", plots, ERASE_ON ? NPIX + 16 : 16);
        end
    endtask

    task automatic test_pending();
        int n;
        model_req(30, 20, 3'b001);
        n = exp_q.size();
        inj_q.push_back('{k: n - 10, x: 8'd20, y: 7'd116, c: 3'b010});
        inj_q.push_back('{k: n - 5,  x: 8'd22, y: 7'd116, c: 3'b010});
        start_req(8'd30, 7'd20, 3'b001);
        capture();
        n_checks++;
        if (lat !== n + 1) begin
            n_fail++;
            $display("FAIL pending_first_latency: got %0d expected %0d", lat, n + 1);
        end
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL pending_first_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
        step();
        model_req(22, 116, 3'b010);
        capture();
        n_checks++;
        if (lat !== exp_q.size() + 1) begin
            n_fail++;
            $display("FAIL pending_second_latency: got %0d expected %0d", lat, exp_q.size() + 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL pending_second_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
    endtask

    task automatic test_go_in_done();
        model_req(50, 60, 3'b100);
        inj_q.push_back('{k: exp_q.size() + 1, x: 8'd70, y: 7'd30, c: 3'b110});
        start_req(8'd50, 7'd60, 3'b100);
        capture();
        n_checks++;
        if (lat !== exp_q.size() + 1) begin
            n_fail++;
            $display("FAIL done_go_first_latency: got %0d expected %0d", lat, exp_q.size() + 1);
        end
        step();
        model_req(70, 30, 3'b110);
        capture();
        n_checks++;
        if (lat !== exp_q.size() + 1) begin
            n_fail++;
            $display("FAIL done_go_second_latency: got %0d expected %0d", lat, exp_q.size() + 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL done_go_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        k = ((ERASE_ON && m_old_valid) ? NPIX : 0) + 6;
        start_req(8'd40, 7'd50, 3'b011);
        repeat (k - 1) @(negedge clk);
        n_checks++;
        if ({ifc.plot, ifc.x, ifc.y, ifc.c} !== {1'b1, 8'd45, 7'd50, 3'b011}) begin
            n_fail++;
            $display("FAIL reset_mid_pixel5: got %h expected %h", {ifc.plot, ifc.x, ifc.y, ifc.c},
                     {1'b1, 8'd45, 7'd50, 3'b011});
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_checks++;
        if ({ifc.plot, ifc.busy, ifc.done, ifc.x, ifc.y, ifc.c} !== 21'd0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %h expected 0",
                     {ifc.plot, ifc.busy, ifc.done, ifc.x, ifc.y, ifc.c});
        end
        m_old_valid = 1'b0;
        model_req(44, 50, 3'b011);
        start_req(8'd44, 7'd50, 3'b011);
        capture();
        n_checks++;
        if (lat !== NPIX + 1) begin
            n_fail++;
            $display("FAIL reset_mid_next_latency: got %0d expected %0d", lat, NPIX + 1);
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            n_checks++;
            if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                n_fail++;
                $display("FAIL reset_mid_next_pixel[%0d]: got %h expected %h", i,
                         (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] rx, px;
        logic [6:0] ry, py;
        logic [2:0] rc, pc;
        bit         inj;
        for (int t = 0; t < 6; t++) begin
            rx  = 8'($urandom_range(0, 255));
            ry  = 7'($urandom_range(0, 127));
            rc  = 3'($urandom_range(0, 7));
            px  = 8'($urandom_range(0, 255));
            py  = 7'($urandom_range(0, 127));
            pc  = 3'($urandom_range(0, 7));
            inj = ($urandom_range(0, 1) == 1);
            model_req(int'(rx), int'(ry), rc);
            if (inj)
                inj_q.push_back('{k: int'($urandom_range(1, exp_q.size() + 1)), x: px, y: py, c: pc});
            start_req(rx, ry, rc);
            capture();
            n_checks++;
            if (lat !== exp_q.size() + 1) begin
                n_fail++;
                $display("FAIL random%0d_latency: got %0d expected %0d", t, lat, exp_q.size() + 1);
            end
            for (int i = 0; i < exp_q.size(); i++) begin
                n_checks++;
                if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                    n_fail++;
                    $display("FAIL random%0d_pixel[%0d]: got %h expected %h", t, i,
                             (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
                end
            end
            if (inj) begin
                step();
                model_req(int'(px), int'(py), pc);
                capture();
                n_checks++;
                if (lat !== exp_q.size() + 1) begin
                    n_fail++;
                    $display("FAIL random%0d_pend_latency: got %0d expected %0d", t, lat, exp_q.size() + 1);
                end
                for (int i = 0; i < exp_q.size(); i++) begin
                    n_checks++;
                    if (i >= obs_q.size() || obs_q[i] !== {2'b10, exp_q[i]}) begin
                        n_fail++;
                        $display("FAIL random%0d_pend_pixel[%0d]: got %h expected %h", t, i,
                                 (i < obs_q.size()) ? obs_q[i] : 21'h0, {2'b10, exp_q[i]});
                    end
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_draw();
        test_second_draw();
        test_offscreen();
        test_pending();
        test_go_in_done();
        test_reset_mid();
        test_random();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
